// File: rtl/x2_pkg.sv
// Shared types and pure functions for the x2 6-bit key interface:
// the forward decoder, its canonical inverse and the decoder-image test.
package x2_pkg;

   localparam int X2_PO_W = 7;
   localparam int X2_K_W  = 6;

   typedef logic [X2_PO_W-1:0] po_t;
   typedef logic [X2_K_W-1:0]  key_t;

   // Forward x2 decoder (key -> observed outputs); k0 has no effect on the outputs.
   function automatic po_t x2_h6_fwd(key_t k);
      po_t p;
      p[0] = k[5] | k[4] | k[1];
      p[1] = k[2];
      p[2] = k[5];
      p[3] = k[5] | k[4] | k[3] | k[2] | k[1];
      p[4] = k[5] | k[4];
      p[5] = k[5] | k[3];
      p[6] = k[5];
      return p;
   endfunction

   // Minimal (canonical) key that reproduces p when p is legal.
   // k5 masks k4, k3 and k1 in every output, so those bits are dropped when po6 is set.
   function automatic key_t x2_k6_inv(po_t p);
      key_t k;
      // NOTE: k is written on every path so this function never infers a latch
      // when it is inlined into combinational logic.
      if (p[6]) begin
         k = {1'b1, 2'b00, p[1], 2'b00};
      end else begin
         k = {1'b0, p[4], p[5], p[1], p[0] & ~p[4], 1'b0};
      end
      return k;
   endfunction

   // 1 when some key produces p through the forward decoder.
   function automatic bit x2_po_legal(po_t p);
      bit ok;
      if (p[6]) begin
         ok = p[2] & p[4] & p[5] & p[0] & p[3];
      end else begin
         ok = ~(p[2] | (p[4] & ~p[0]) | (p[3] != (p[0] | p[1] | p[4] | p[5])));
      end
      return ok;
   endfunction

endpackage

// File: rtl/x2_k6_inv_comb.sv
// Combinational key recovery and illegal-vector flag between S1 and S2.
module x2_k6_inv_comb
   import x2_pkg::*;
(
   input  logic [X2_PO_W-1:0] i_po,
   output logic [X2_K_W-1:0]  o_k,
   output logic               o_err
);

   assign o_k   = x2_k6_inv(i_po);
   assign o_err = ~x2_po_legal(i_po);

endmodule

// File: rtl/x2_k6_recover.sv
// Two-stage valid/ready pipeline that rebuilds canonical x2 keys from observed
// output vectors, flags vectors outside the decoder image, and keeps
// saturating word/error statistics on delivered words.
module x2_k6_recover
   import x2_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [X2_PO_W-1:0] in_po,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [X2_K_W-1:0]  out_k,
   output logic               out_err,
   input  logic               clr,
   output logic [CNT_W-1:0]   word_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic               err_sticky
);

   logic               r_s1_valid;
   po_t                r_s1_po;
   logic               r_s2_valid;
   key_t               r_s2_k;
   logic               r_s2_err;
   logic [CNT_W-1:0]   r_word_cnt;
   logic [CNT_W-1:0]   r_err_cnt;
   logic               r_err_sticky;

   logic               w_adv2;
   logic               w_in_fire;
   logic               w_out_fire;
   key_t               w_k;
   logic               w_err;

   // S2 can take a word when empty or when its word leaves this cycle.
   assign w_adv2     = ~r_s2_valid | out_ready;
   assign in_ready   = ~r_s1_valid | w_adv2;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_s2_valid & out_ready;

   x2_k6_inv_comb u_inv (
      .i_po  (r_s1_po),
      .o_k   (w_k),
      .o_err (w_err)
   );

   // Stage S1: capture the observed vector on the input handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_po    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_po    <= in_po;
         end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   // Stage S2: register the recovered key; held steady while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_k     <= '0;
         r_s2_err   <= 1'b0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_k   <= w_k;
            r_s2_err <= w_err;
         end
      end
   end

   // Statistics on delivered words; clr wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_cnt   <= '0;
         r_err_cnt    <= '0;
         r_err_sticky <= 1'b0;
      end else if (clr) begin
         r_word_cnt   <= '0;
         r_err_cnt    <= '0;
         r_err_sticky <= 1'b0;
      end else if (w_out_fire) begin
         if (r_word_cnt != '1) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
         end
         if (r_s2_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != '1) begin
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign out_k      = r_s2_k;
   assign out_err    = r_s2_err;
   assign word_cnt   = r_word_cnt;
   assign err_cnt    = r_err_cnt;
   assign err_sticky = r_err_sticky;

endmodule
